partition_stats: RTL and testbench

Streaming partition actor for the median filter's iterative pivot search. Once per iteration it latches the pivot and search parameters, consumes the current buffer's pixel stream, classifies each pixel against the pivot, and counts lower, equal and larger pixels. It also tracks min/max of the lower and larger sets and forwards each classified pixel to the buffer writer. When the stream ends it presents sizes, extrema and sampled parameters to the next-pivot logic with a one-cycle `up_next` pulse.

---
 rtl/partition_stats_pkg.sv | 28 ++
 rtl/partition_stats_if.sv | 11 +
 rtl/minmax_track.sv | 26 ++
 rtl/partition_stats.sv | 151 +++++++++++++++
 tb/tb_partition_stats.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/partition_stats_pkg.sv
// Shared definitions for the median filter partition actor: compare cases,
// pixel classes, FSM states and the default buffer size.
package median_pkg;

    localparam logic [10:0] DEF_BUFF_SIZE = 11'd1024;

    // Compare case is {data > pivot, data >= pivot}; EQ1 cannot occur and is
    // folded into the equal class.
    localparam logic [1:0] LOW  = 2'b00;
    localparam logic [1:0] EQ0  = 2'b01;
    localparam logic [1:0] EQ1  = 2'b10;
    localparam logic [1:0] LARG = 2'b11;

    localparam logic [1:0] CLS_LOW  = 2'b00;
    localparam logic [1:0] CLS_EQ   = 2'b01;
    localparam logic [1:0] CLS_LARG = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        REPORT = 2'd2
    } state_e;

    function automatic logic [1:0] cmp_case(input logic [7:0] data, input logic [7:0] pivot);
        return {data > pivot, data >= pivot};
    endfunction

endpackage

// File: rtl/partition_stats_if.sv
// Pixel input stream into the partition actor.
// A beat transfers on a rising edge where s_valid and s_ready are both high;
// s_data is only meaningful while s_valid is high, and s_ready never depends on s_valid.
interface partition_stats_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/minmax_track.sv
// Running 8-bit min/max of the values presented with en; clr restarts the
// tracker at min=255, max=0 so an empty set is recognisable downstream.
module minmax_track (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] din,
    output logic [7:0] min_val,
    output logic [7:0] max_val
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_val <= 8'd255;
            max_val <= 8'd0;
        end else if (clr) begin
            min_val <= 8'd255;
            max_val <= 8'd0;
        end else if (en) begin
            if (din < min_val) min_val <= din;
            if (din > max_val) max_val <= din;
        end
    end

endmodule

// File: rtl/partition_stats.sv
// Partition actor for the iterative pivot search: classifies one buffer's pixel
// stream against the pivot, counts and tracks extrema, and reports with up_next.
module partition_stats
    import median_pkg::*;
#(
    parameter logic [10:0] BUFF_SIZE     = DEF_BUFF_SIZE,
    parameter int          BUFF_SIZE_BIT = $clog2(BUFF_SIZE) + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [7:0]               in_pivot,
    input  logic [BUFF_SIZE_BIT-1:0] in_buff_size,
    input  logic [BUFF_SIZE_BIT-1:0] in_median_pos,
    input  logic [7:0]               in_second_median_value,
    partition_stats_if.slave         s,
    output logic [7:0]               out_data,
    output logic [1:0]               out_class,
    output logic                     out_valid,
    output logic [BUFF_SIZE_BIT-1:0] lower_size,
    output logic [BUFF_SIZE_BIT-1:0] equal_size,
    output logic [BUFF_SIZE_BIT-1:0] larger_size,
    output logic [8:0]               max_lower,
    output logic [8:0]               min_lower,
    output logic [8:0]               max_larger,
    output logic [8:0]               min_larger,
    output logic [BUFF_SIZE_BIT-1:0] in_buff_size_samp,
    output logic [BUFF_SIZE_BIT-1:0] in_median_pos_samp,
    output logic [8:0]               in_pivot_samp,
    output logic [8:0]               in_second_median_value_samp,
    output logic                     up_next,
    output logic                     busy,
    output logic                     done,
    output logic [1:0]               state_dbg
);

    localparam logic [BUFF_SIZE_BIT-1:0] ONE = BUFF_SIZE_BIT'(1);

    state_e                   state, state_nxt;
    logic [BUFF_SIZE_BIT-1:0] consumed;
    logic [BUFF_SIZE_BIT-1:0] consumed_inc;
    logic                     start_acc;
    logic                     beat;
    logic [1:0]               cls;
    logic                     lower_hit, larger_hit;
    logic [7:0]               min_lo, max_lo, min_la, max_la;

    assign start_acc    = start && (state == IDLE);
    assign beat         = s.s_valid && s.s_ready;
    assign consumed_inc = consumed + ONE;

    always_comb begin
        cls = CLS_EQ;
        case (cmp_case(s.s_data, in_pivot_samp[7:0]))
            LOW:     cls = CLS_LOW;
            LARG:    cls = CLS_LARG;
            default: cls = CLS_EQ;
        endcase
    end

    assign lower_hit  = beat && (cls == CLS_LOW);
    assign larger_hit = beat && (cls == CLS_LARG);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (in_buff_size == '0) ? REPORT : RUN;
            RUN:     if (beat && (consumed_inc == in_buff_size_samp)) state_nxt = REPORT;
            REPORT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            consumed                    <= '0;
            lower_size                  <= '0;
            equal_size                  <= '0;
            larger_size                 <= '0;
            out_data                    <= 8'd0;
            out_class                   <= 2'b00;
            out_valid                   <= 1'b0;
            done                        <= 1'b0;
            in_pivot_samp               <= 9'd127;
            in_second_median_value_samp <= 9'd127;
            in_buff_size_samp           <= BUFF_SIZE_BIT'(BUFF_SIZE);
            in_median_pos_samp          <= BUFF_SIZE_BIT'(BUFF_SIZE >> 1);
        end else begin
            out_valid <= beat;
            if (start_acc) begin
                in_pivot_samp               <= {1'b0, in_pivot};
                in_second_median_value_samp <= {1'b0, in_second_median_value};
                in_buff_size_samp           <= in_buff_size;
                in_median_pos_samp          <= in_median_pos;
                consumed                    <= '0;
                lower_size                  <= '0;
                equal_size                  <= '0;
                larger_size                 <= '0;
                done                        <= 1'b0;
            end
            if (beat) begin
                consumed  <= consumed_inc;
                out_data  <= s.s_data;
                out_class <= cls;
                case (cls)
                    CLS_LOW:  lower_size  <= lower_size + ONE;
                    CLS_LARG: larger_size <= larger_size + ONE;
                    default:  equal_size  <= equal_size + ONE;
                endcase
            end
            // Results become valid on entry to REPORT, including the zero-size path.
            if (state_nxt == REPORT) done <= 1'b1;
        end
    end

    minmax_track u_lower (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (start_acc),
        .en      (lower_hit),
        .din     (s.s_data),
        .min_val (min_lo),
        .max_val (max_lo)
    );

    minmax_track u_larger (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (start_acc),
        .en      (larger_hit),
        .din     (s.s_data),
        .min_val (min_la),
        .max_val (max_la)
    );

    assign min_lower  = {1'b0, min_lo};
    assign max_lower  = {1'b0, max_lo};
    assign min_larger = {1'b0, min_la};
    assign max_larger = {1'b0, max_la};

    assign s.s_ready = (state == RUN);
    assign up_next   = (state == REPORT);
    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_partition_stats.sv
// Directed bench for partition_stats: hand-computed vectors checked with
// immediate assertions at each step.
module tb_partition_stats;
    import median_pkg::*;

    localparam int BSB = 11;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [7:0]     in_pivot = 8'd0;
    logic [BSB-1:0] in_buff_size = '0;
    logic [BSB-1:0] in_median_pos = '0;
    logic [7:0]     in_second_median_value = 8'd0;
    logic [7:0]     out_data;
    logic [1:0]     out_class;
    logic           out_valid;
    logic [BSB-1:0] lower_size, equal_size, larger_size;
    logic [8:0]     max_lower, min_lower, max_larger, min_larger;
    logic [BSB-1:0] in_buff_size_samp, in_median_pos_samp;
    logic [8:0]     in_pivot_samp, in_second_median_value_samp;
    logic           up_next, busy, done;
    logic [1:0]     state_dbg;

    int total = 0;
    int bad = 0;
    int ov_cnt = 0;
    int un_cnt = 0;
    int rdy_cnt = 0;

    always #5 clk = ~clk;

    partition_stats_if s_if ();

    partition_stats #(.BUFF_SIZE(11'd1024)) dut (
        .clk                         (clk),
        .rst_n                       (rst_n),
        .start                       (start),
        .in_pivot                    (in_pivot),
        .in_buff_size                (in_buff_size),
        .in_median_pos               (in_median_pos),
        .in_second_median_value      (in_second_median_value),
        .s                           (s_if.slave),
        .out_data                    (out_data),
        .out_class                   (out_class),
        .out_valid                   (out_valid),
        .lower_size                  (lower_size),
        .equal_size                  (equal_size),
        .larger_size                 (larger_size),
        .max_lower                   (max_lower),
        .min_lower                   (min_lower),
        .max_larger                  (max_larger),
        .min_larger                  (min_larger),
        .in_buff_size_samp           (in_buff_size_samp),
        .in_median_pos_samp          (in_median_pos_samp),
        .in_pivot_samp               (in_pivot_samp),
        .in_second_median_value_samp (in_second_median_value_samp),
        .up_next                     (up_next),
        .busy                        (busy),
        .done                        (done),
        .state_dbg                   (state_dbg)
    );

    always @(negedge clk) begin
        if (out_valid)      ov_cnt++;
        if (up_next)        un_cnt++;
        if (s_if.s_ready)   rdy_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] pv, input int sz, input int mp, input logic [7:0] sec);
        start = 1'b1;
        in_pivot = pv;
        in_buff_size = BSB'(sz);
        in_median_pos = BSB'(mp);
        in_second_median_value = sec;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] px, input int gap);
        logic rdy;
        int   waited;
        s_if.s_valid = 1'b0;
        repeat (gap) tick();
        s_if.s_data  = px;
        s_if.s_valid = 1'b1;
        waited = 0;
        forever begin
            rdy = s_if.s_ready;
            tick();
            if (rdy) break;
            waited++;
            if (waited > 64) begin
                total++;
                bad++;
                $error("FAIL beat_timeout: got no s_ready want s_ready within 64 cycles");
                break;
            end
        end
        s_if.s_valid = 1'b0;
    endtask

    task automatic check_reset_vals();
        chk("rst_s_ready",   s_if.s_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_up_next",   up_next, 0);
        chk("rst_busy",      busy, 0);
        chk("rst_done",      done, 0);
        chk("rst_lower",     lower_size, 0);
        chk("rst_equal",     equal_size, 0);
        chk("rst_larger",    larger_size, 0);
        chk("rst_out_data",  out_data, 0);
        chk("rst_out_class", out_class, 0);
        chk("rst_min_lower", min_lower, 255);
        chk("rst_max_lower", max_lower, 0);
        chk("rst_min_larger", min_larger, 255);
        chk("rst_max_larger", max_larger, 0);
        chk("rst_pivot_samp", in_pivot_samp, 127);
        chk("rst_sec_samp",  in_second_median_value_samp, 127);
        chk("rst_size_samp", in_buff_size_samp, 1024);
        chk("rst_pos_samp",  in_median_pos_samp, 512);
    endtask

    initial begin
        int ov0, un0, rdy0;
        s_if.s_data  = 8'd0;
        s_if.s_valid = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals();
        rst_n = 1'b1;
        tick();

        // basic partition: pivot 100, {50,100,150,20}
        do_start(8'd100, 4, 2, 8'd77);
        chk("t1_ready_after_start", s_if.s_ready, 1);
        chk("t1_busy", busy, 1);
        chk("t1_done_low", done, 0);
        send(8'd50, 0);
        send(8'd100, 0);
        send(8'd150, 0);
        chk("t1_no_up_next_early", up_next, 0);
        send(8'd20, 0);
        chk("t1_up_next", up_next, 1);
        chk("t1_ready_low", s_if.s_ready, 0);
        chk("t1_done", done, 1);
        chk("t1_lower", lower_size, 2);
        chk("t1_equal", equal_size, 1);
        chk("t1_larger", larger_size, 1);
        chk("t1_min_lower", min_lower, 20);
        chk("t1_max_lower", max_lower, 50);
        chk("t1_min_larger", min_larger, 150);
        chk("t1_max_larger", max_larger, 150);
        chk("t1_out_data", out_data, 20);
        chk("t1_out_class", out_class, 0);
        chk("t1_out_valid", out_valid, 1);
        chk("t1_pivot_samp", in_pivot_samp, 100);
        chk("t1_size_samp", in_buff_size_samp, 4);
        chk("t1_pos_samp", in_median_pos_samp, 2);
        chk("t1_sec_samp", in_second_median_value_samp, 77);
        tick();
        chk("t1_up_next_pulse", up_next, 0);
        chk("t1_idle", busy, 0);
        chk("t1_done_held", done, 1);
        chk("t1_lower_held", lower_size, 2);

        // zero-size iteration
        rdy0 = rdy_cnt;
        un0  = un_cnt;
        do_start(8'd9, 0, 0, 8'd5);
        chk("t2_up_next", up_next, 1);
        chk("t2_ready", s_if.s_ready, 0);
        chk("t2_done", done, 1);
        chk("t2_lower", lower_size, 0);
        chk("t2_equal", equal_size, 0);
        chk("t2_larger", larger_size, 0);
        chk("t2_min_lower", min_lower, 255);
        chk("t2_max_lower", max_lower, 0);
        chk("t2_min_larger", min_larger, 255);
        chk("t2_max_larger", max_larger, 0);
        tick();
        chk("t2_ready_never", rdy_cnt - rdy0, 0);
        chk("t2_up_next_once", un_cnt - un0, 1);

        // full buffer of equal pixels with random valid gaps
        ov0 = ov_cnt;
        un0 = un_cnt;
        do_start(8'd127, 1024, 512, 8'd3);
        for (int i = 0; i < 1024; i++) send(8'd127, $urandom_range(0, 2));
        chk("t3_up_next", up_next, 1);
        chk("t3_equal", equal_size, 1024);
        chk("t3_lower", lower_size, 0);
        chk("t3_larger", larger_size, 0);
        tick();
        tick();
        chk("t3_out_valid_cnt", ov_cnt - ov0, 1024);
        chk("t3_up_next_once", un_cnt - un0, 1);

        // start during RUN is ignored
        do_start(8'd50, 6, 3, 8'd1);
        send(8'd10, 0);
        send(8'd50, 0);
        start = 1'b1;
        in_pivot = 8'd200;
        tick();
        start = 1'b0;
        chk("t4_still_run", s_if.s_ready, 1);
        chk("t4_pivot_kept", in_pivot_samp, 50);
        send(8'd60, 0);
        send(8'd70, 0);
        send(8'd50, 0);
        send(8'd5, 0);
        chk("t4_up_next", up_next, 1);
        chk("t4_lower", lower_size, 2);
        chk("t4_equal", equal_size, 2);
        chk("t4_larger", larger_size, 2);
        chk("t4_min_lower", min_lower, 5);
        chk("t4_max_lower", max_lower, 10);
        chk("t4_min_larger", min_larger, 60);
        chk("t4_max_larger", max_larger, 70);
        chk("t4_pivot_samp", in_pivot_samp, 50);
        tick();
        tick();

        // reset mid-RUN
        un0 = un_cnt;
        do_start(8'd128, 20, 10, 8'd1);
        for (int i = 0; i < 10; i++) send(8'(i * 20), 0);
        chk("t5_mid_lower", lower_size, 7);
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        tick();
        tick();
        chk("t5_no_up_next", un_cnt - un0, 0);
        chk("t5_idle", busy, 0);
        rst_n = 1'b1;
        tick();

        // pivot 0 after reset: {0,255,1}
        do_start(8'd0, 3, 1, 8'd200);
        send(8'd0, 0);
        send(8'd255, 0);
        send(8'd1, 0);
        chk("t6_up_next", up_next, 1);
        chk("t6_lower", lower_size, 0);
        chk("t6_equal", equal_size, 1);
        chk("t6_larger", larger_size, 2);
        chk("t6_min_larger", min_larger, 1);
        chk("t6_max_larger", max_larger, 255);
        chk("t6_min_lower", min_lower, 255);
        chk("t6_max_lower", max_lower, 0);
        chk("t6_out_class", out_class, 3);
        chk("t6_sec_samp", in_second_median_value_samp, 200);
        tick();
        chk("t6_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
